// File: rtl/vx_bank_rsp_queue.sv
// Bank response queue: aligns request metadata with the registered data-store read,
// picks the addressed word and buffers responses. Optional perf counters: VX_BANK_RSPQ_PERF_EN.
module vx_bank_rsp_queue #(
  parameter int CACHE_LINE_SIZE = 64,
  parameter int WORD_SIZE       = 4,
  parameter int RSPQ_SIZE       = 4,
  parameter int TAG_WIDTH       = 16,
  parameter int NUM_REQS        = 4,
  localparam int TID_W  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
  localparam int WSEL_W = ((CACHE_LINE_SIZE / WORD_SIZE) > 1) ? $clog2(CACHE_LINE_SIZE / WORD_SIZE) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         rd_valid,
  output logic                         rd_ready,
  input  logic [WSEL_W-1:0]            rd_wsel,
  input  logic [TAG_WIDTH-1:0]         rd_tag,
  input  logic [TID_W-1:0]             rd_tid,
  input  logic [CACHE_LINE_SIZE*8-1:0] line_data,
  output logic                         core_rsp_valid,
  input  logic                         core_rsp_ready,
  output logic [WORD_SIZE*8-1:0]       core_rsp_data,
  output logic [TAG_WIDTH-1:0]         core_rsp_tag,
  output logic [TID_W-1:0]             core_rsp_tid,
  output logic                         almost_full
`ifdef VX_BANK_RSPQ_PERF_EN
  ,
  output logic [31:0]                  perf_rsp_stalls,
  output logic [31:0]                  perf_issue_stalls
`endif
);

  localparam int WORD_W    = WORD_SIZE * 8;
  localparam int NUM_WORDS = CACHE_LINE_SIZE / WORD_SIZE;
  localparam int PTR_W     = $clog2(RSPQ_SIZE);
  localparam int CNT_W     = PTR_W + 1;

  localparam logic [CNT_W:0]   RES_FULL = (CNT_W+1)'(RSPQ_SIZE);
  localparam logic [CNT_W:0]   RES_AF   = (CNT_W+1)'(RSPQ_SIZE - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RSPQ_SIZE);

  // S1 metadata, aligned with line_data one cycle after issue
  logic                 s1_valid;
  logic [WSEL_W-1:0]    s1_wsel;
  logic [TAG_WIDTH-1:0] s1_tag;
  logic [TID_W-1:0]     s1_tid;

  logic [WORD_W-1:0]    data_mem [RSPQ_SIZE];
  logic [TAG_WIDTH-1:0] tag_mem  [RSPQ_SIZE];
  logic [TID_W-1:0]     tid_mem  [RSPQ_SIZE];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;

  logic                 rd_ready_r;
  logic                 almost_full_r;

  logic                 fire;
  logic                 push;
  logic                 pop;
  logic [WORD_W-1:0]    line_words [NUM_WORDS];
  logic [WORD_W-1:0]    s1_word;
  logic [CNT_W-1:0]     count_n;
  logic [CNT_W:0]       reserved_n;

  for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_words
    assign line_words[gi] = line_data[gi*WORD_W +: WORD_W];
  end

  assign s1_word        = line_words[s1_wsel];
  assign fire           = rd_valid & rd_ready_r;
  assign push           = s1_valid;
  assign core_rsp_valid = (count != '0);
  assign pop            = core_rsp_valid & core_rsp_ready;

  assign rd_ready       = rd_ready_r;
  assign almost_full    = almost_full_r;
  assign core_rsp_data  = data_mem[rd_ptr];
  assign core_rsp_tag   = tag_mem[rd_ptr];
  assign core_rsp_tid   = tid_mem[rd_ptr];

  // Credits look at next-cycle occupancy plus the read about to land in S1,
  // so a same-cycle pop only frees its slot for the following cycle.
  always_comb begin
    count_n = count;
    case ({push, pop})
      2'b10:   count_n = count + 1'b1;
      2'b01:   count_n = count - 1'b1;
      default: count_n = count;
    endcase
    reserved_n = {1'b0, count_n} + (CNT_W+1)'(fire);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid      <= 1'b0;
      s1_wsel       <= '0;
      s1_tag        <= '0;
      s1_tid        <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      rd_ready_r    <= 1'b1;
      almost_full_r <= 1'b0;
    end else begin
      s1_valid <= fire;
      if (fire) begin
        s1_wsel <= rd_wsel;
        s1_tag  <= rd_tag;
        s1_tid  <= rd_tid;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count         <= count_n;
      rd_ready_r    <= (reserved_n < RES_FULL);
      almost_full_r <= (reserved_n >= RES_AF);
    end
  end

  // Storage is cleared on reset so the head outputs read as zero when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < RSPQ_SIZE; i++) begin
        data_mem[i] <= '0;
        tag_mem[i]  <= '0;
        tid_mem[i]  <= '0;
      end
    end else if (push) begin
      data_mem[wr_ptr] <= s1_word;
      tag_mem[wr_ptr]  <= s1_tag;
      tid_mem[wr_ptr]  <= s1_tid;
    end
  end

`ifdef VX_BANK_RSPQ_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_rsp_stalls   <= '0;
      perf_issue_stalls <= '0;
    end else begin
      if (core_rsp_valid && !core_rsp_ready && (perf_rsp_stalls != '1)) begin
        perf_rsp_stalls <= perf_rsp_stalls + 32'd1;
      end
      if (rd_valid && !rd_ready_r && (perf_issue_stalls != '1)) begin
        perf_issue_stalls <= perf_issue_stalls + 32'd1;
      end
    end
  end
`endif

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && (count == CNT_FULL)))
    else $error("response queue push while full");
`endif

endmodule

// File: tb/tb_vx_bank_rsp_queue.sv
// Directed bench for vx_bank_rsp_queue: vector table plus hand-written
// backpressure, wrap-around, reset and (optional) perf-counter sequences.
module tb_vx_bank_rsp_queue;

  logic         clk;
  logic         reset;
  logic         rd_valid;
  logic         rd_ready;
  logic [3:0]   rd_wsel;
  logic [15:0]  rd_tag;
  logic [1:0]   rd_tid;
  logic [511:0] line_data;
  logic         core_rsp_valid;
  logic         core_rsp_ready;
  logic [31:0]  core_rsp_data;
  logic [15:0]  core_rsp_tag;
  logic [1:0]   core_rsp_tid;
  logic         almost_full;
`ifdef VX_BANK_RSPQ_PERF_EN
  logic [31:0]  perf_rsp_stalls;
  logic [31:0]  perf_issue_stalls;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  vx_bank_rsp_queue #(
    .CACHE_LINE_SIZE(64),
    .WORD_SIZE(4),
    .RSPQ_SIZE(4),
    .TAG_WIDTH(16),
    .NUM_REQS(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rd_valid(rd_valid),
    .rd_ready(rd_ready),
    .rd_wsel(rd_wsel),
    .rd_tag(rd_tag),
    .rd_tid(rd_tid),
    .line_data(line_data),
    .core_rsp_valid(core_rsp_valid),
    .core_rsp_ready(core_rsp_ready),
    .core_rsp_data(core_rsp_data),
    .core_rsp_tag(core_rsp_tag),
    .core_rsp_tid(core_rsp_tid),
    .almost_full(almost_full)
`ifdef VX_BANK_RSPQ_PERF_EN
    ,
    .perf_rsp_stalls(perf_rsp_stalls),
    .perf_issue_stalls(perf_issue_stalls)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mk_word(input logic [15:0] t, input int i);
    if (t == 16'h00A5 && i == 3) return 32'hDEADBEEF;
    return {t, 8'(i), 8'h5A};
  endfunction

  function automatic logic [511:0] mk_line(input logic [15:0] t);
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = mk_word(t, i);
    return l;
  endfunction

  // Data-store model: line for the issued tag appears the cycle after issue
  initial line_data = '0;
  always @(posedge clk) begin
    if (rd_valid && rd_ready) line_data <= mk_line(rd_tag);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] w, input logic [15:0] t,
                       input logic [1:0] id, input logic crr);
    rd_valid       = v;
    rd_wsel        = w;
    rd_tag         = t;
    rd_tid         = id;
    core_rsp_ready = crr;
  endtask

  typedef struct {
    logic        rv;
    logic [3:0]  wsel;
    logic [15:0] tag;
    logic [1:0]  tid;
    logic        crr;
    logic        ev;
    logic [31:0] ed;
    logic [15:0] et;
    logic [1:0]  eid;
    logic        erdy;
    logic        eaf;
  } vec_t;

  vec_t vt [15];

  typedef struct {
    logic [31:0] d;
    logic [15:0] t;
    logic [1:0]  id;
  } rsp_t;

  rsp_t sb [$];

  bit bp_rdy [13] = '{1,1,1,1,0,0,0,0,0,1,1,1,1};
  bit bp_val [13] = '{0,0,1,1,1,1,1,1,1,1,1,1,0};
  bit bp_af  [13] = '{0,0,0,1,1,1,1,1,1,1,0,0,0};
  int bp_head[13] = '{-1,-1,0,0,0,0,0,0,0,1,2,3,-1};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int issued;
    int got;
    rsp_t e;

    // Rows 0-3: single read; rows 4-14: 8 back-to-back reads
    for (int r = 0; r < 15; r++) begin
      vt[r] = '{rv:1'b0, wsel:4'd0, tag:16'd0, tid:2'd0, crr:1'b1, ev:1'b0,
                ed:32'd0, et:16'd0, eid:2'd0, erdy:1'b1, eaf:1'b0};
    end
    vt[0].rv = 1'b1; vt[0].wsel = 4'd3; vt[0].tag = 16'h00A5; vt[0].tid = 2'd2;
    vt[2].ev = 1'b1; vt[2].ed = 32'hDEADBEEF; vt[2].et = 16'h00A5; vt[2].eid = 2'd2;
    for (int r = 4; r < 15; r++) begin
      int k;
      int j;
      k = r - 4;
      j = k - 2;
      if (k < 8) begin
        vt[r].rv   = 1'b1;
        vt[r].wsel = 4'(k);
        vt[r].tag  = 16'h1000 + 16'(k);
        vt[r].tid  = 2'(k % 4);
      end
      if (k >= 2 && k <= 9) begin
        vt[r].ev  = 1'b1;
        vt[r].ed  = mk_word(16'h1000 + 16'(j), j);
        vt[r].et  = 16'h1000 + 16'(j);
        vt[r].eid = 2'(j % 4);
      end
    end

    reset = 1'b1;
    drive(1'b0, 4'd0, 16'd0, 2'd0, 1'b1);
    tick();
    tick();
    chk("reset valid", 32'(core_rsp_valid), 32'd0);
    chk("reset rd_ready", 32'(rd_ready), 32'd1);
    chk("reset almost_full", 32'(almost_full), 32'd0);
    chk("reset data", core_rsp_data, 32'd0);
    chk("reset tag", 32'(core_rsp_tag), 32'd0);
    chk("reset tid", 32'(core_rsp_tid), 32'd0);
    reset = 1'b0;

    for (int r = 0; r < 15; r++) begin
      drive(vt[r].rv, vt[r].wsel, vt[r].tag, vt[r].tid, vt[r].crr);
      chk($sformatf("vec%0d valid", r), 32'(core_rsp_valid), 32'(vt[r].ev));
      chk($sformatf("vec%0d rd_ready", r), 32'(rd_ready), 32'(vt[r].erdy));
      chk($sformatf("vec%0d almost_full", r), 32'(almost_full), 32'(vt[r].eaf));
      if (vt[r].ev) begin
        chk($sformatf("vec%0d data", r), core_rsp_data, vt[r].ed);
        chk($sformatf("vec%0d tag", r), 32'(core_rsp_tag), 32'(vt[r].et));
        chk($sformatf("vec%0d tid", r), 32'(core_rsp_tid), 32'(vt[r].eid));
      end
      tick();
    end

    // Backpressure: consumer stalled while upstream keeps issuing
    for (int c = 0; c < 13; c++) begin
      drive(c <= 8, 4'(c), 16'h2000 + 16'(c), 2'(c % 4), c >= 8);
      chk($sformatf("bp%0d rd_ready", c), 32'(rd_ready), 32'(bp_rdy[c]));
      chk($sformatf("bp%0d valid", c), 32'(core_rsp_valid), 32'(bp_val[c]));
      chk($sformatf("bp%0d almost_full", c), 32'(almost_full), 32'(bp_af[c]));
      if (bp_head[c] >= 0) begin
        chk($sformatf("bp%0d data", c), core_rsp_data, mk_word(16'h2000 + 16'(bp_head[c]), bp_head[c]));
        chk($sformatf("bp%0d tag", c), 32'(core_rsp_tag), 32'h2000 + 32'(bp_head[c]));
        chk($sformatf("bp%0d tid", c), 32'(core_rsp_tid), 32'(bp_head[c] % 4));
      end
      tick();
    end

    // Wrap-around: ready toggles 1010..., 10 responses through the ring
    issued = 0;
    got    = 0;
    for (int cyc = 0; cyc < 80 && got < 10; cyc++) begin
      drive(issued < 10, 4'((issued * 5) % 16), 16'h3000 + 16'(issued), 2'(issued % 4), (cyc % 2) == 0);
      if (core_rsp_valid && core_rsp_ready) begin
        if (sb.size() == 0) begin
          chk("wrap unexpected response", 32'(core_rsp_tag), 32'hFFFFFFFF);
        end else begin
          e = sb.pop_front();
          chk($sformatf("wrap%0d data", got), core_rsp_data, e.d);
          chk($sformatf("wrap%0d tag", got), 32'(core_rsp_tag), 32'(e.t));
          chk($sformatf("wrap%0d tid", got), 32'(core_rsp_tid), 32'(e.id));
        end
        got++;
      end
      if (rd_valid && rd_ready) begin
        e.d  = mk_word(rd_tag, int'(rd_wsel));
        e.t  = rd_tag;
        e.id = rd_tid;
        sb.push_back(e);
        issued++;
      end
      tick();
    end
    chk("wrap response count", 32'(got), 32'd10);

    // Reset with 3 queued plus 1 in S1
    drive(1'b0, 4'd0, 16'd0, 2'd0, 1'b1);
    tick();
    tick();
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 4'(c), 16'h4000 + 16'(c), 2'(c), 1'b0);
      tick();
    end
    drive(1'b0, 4'd0, 16'd0, 2'd0, 1'b0);
    chk("rst pre valid", 32'(core_rsp_valid), 32'd1);
    chk("rst pre rd_ready", 32'(rd_ready), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    core_rsp_ready = 1'b1;
    chk("rst post rd_ready", 32'(rd_ready), 32'd1);
    chk("rst post almost_full", 32'(almost_full), 32'd0);
    chk("rst post data", core_rsp_data, 32'd0);
    chk("rst post tag", 32'(core_rsp_tag), 32'd0);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("rst idle%0d valid", c), 32'(core_rsp_valid), 32'd0);
      tick();
    end
    drive(1'b1, 4'd5, 16'h4444, 2'd1, 1'b1);
    tick();
    drive(1'b0, 4'd0, 16'd0, 2'd0, 1'b1);
    chk("rst new T+1 valid", 32'(core_rsp_valid), 32'd0);
    tick();
    chk("rst new valid", 32'(core_rsp_valid), 32'd1);
    chk("rst new data", core_rsp_data, mk_word(16'h4444, 5));
    chk("rst new tag", 32'(core_rsp_tag), 32'h4444);
    chk("rst new tid", 32'(core_rsp_tid), 32'd1);
    tick();
    chk("rst new drained", 32'(core_rsp_valid), 32'd0);

`ifdef VX_BANK_RSPQ_PERF_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("perf reset rsp", perf_rsp_stalls, 32'd0);
    chk("perf reset issue", perf_issue_stalls, 32'd0);
    for (int c = 0; c < 7; c++) begin
      drive(c < 6, 4'(c), 16'h5000 + 16'(c), 2'(c % 4), 1'b0);
      tick();
    end
    drive(1'b0, 4'd0, 16'd0, 2'd0, 1'b1);
    chk("perf rsp stalls", perf_rsp_stalls, 32'd5);
    chk("perf issue stalls", perf_issue_stalls, 32'd2);
    tick();
    chk("perf rsp hold", perf_rsp_stalls, 32'd5);
    for (int c = 0; c < 6; c++) tick();
    chk("perf drained", 32'(core_rsp_valid), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vx_bank_rsp_queue.md
Name: VX_bank_rsp_queue

Overview:
- Bank stage directly downstream of the data-store read.
- Aligns request metadata with the one-cycle-latency line read data, extracts the addressed word, and buffers responses in a small FIFO toward the core response arbiter.
- Issues read credits upstream, so a read is only started when a FIFO slot is guaranteed.

Parameters:
- CACHE_LINE_SIZE, 64: line size in bytes (power of two).
- WORD_SIZE, 4: word size in bytes (power of two, ≤ CACHE_LINE_SIZE).
- RSPQ_SIZE, 4: response FIFO depth (power of two, ≥ 2).
- TAG_WIDTH, 16: core request tag width.
- NUM_REQS, 4: requestor lanes per bank; TID_W = max(1, log2(NUM_REQS)).
- Derived: WSEL_W = max(1, log2(CACHE_LINE_SIZE/WORD_SIZE)).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- rd_valid  in  1  upstream wants to issue a data-store read this cycle
- rd_ready  out  1  read may issue; upstream drives data-store readen = rd_valid & rd_ready
- rd_wsel  in  WSEL_W  word offset within line
- rd_tag  in  TAG_WIDTH  request tag
- rd_tid  in  TID_W  requestor lane
- line_data  in  CACHE_LINE_SIZE*8  data-store read output, valid the cycle after issue
- core_rsp_valid  out  1  response available
- core_rsp_ready  in  1  consumer accepts
- core_rsp_data  out  WORD_SIZE*8  selected word
- core_rsp_tag  out  TAG_WIDTH  tag
- core_rsp_tid  out  TID_W  lane
- almost_full  out  1  reserved occupancy ≥ RSPQ_SIZE-1

Behaviour:
- Clock `clk`, single domain. Reset `reset` is synchronous and active-high.
- Reset clears the FIFO (count=0, pointers=0) and s1_valid=0. Reset values: core_rsp_valid=0, core_rsp_data/tag/tid=0, rd_ready=1, almost_full=0.
- Reset mid-operation drops any in-flight S1 entry and all queued entries, without producing any response.
- S0 (accept):
  - fire = rd_valid & rd_ready.
  - On fire, register wsel/tag/tid into S1 and set s1_valid=1; otherwise s1_valid=0.
- S1 (align):
  - line_data corresponds to the S1 metadata.
  - word = line_data[wsel*WORD_SIZE*8 +: WORD_SIZE*8].
  - If s1_valid, push {word, tag, tid} into the FIFO at the end of the cycle.
- Credits:
  - reserved = count + s1_valid.
  - rd_ready = (reserved < RSPQ_SIZE), registered-path only; no combinational dependency on core_rsp_ready.
  - A pop in the same cycle frees the credit next cycle, not this one.
  - The FIFO can therefore never overflow; a push into a full FIFO is unreachable and is flagged by an assertion.
- FIFO:
  - Circular buffer with wrap-around pointers of log2(RSPQ_SIZE) bits plus a count of log2(RSPQ_SIZE)+1 bits.
  - Outputs come from registered head data. core_rsp_valid = (count != 0).
  - pop = core_rsp_valid & core_rsp_ready.
  - Simultaneous push and pop leaves count unchanged; both pointers advance.
  - No bypass: an empty FIFO plus a push shows valid on the next cycle.
- Latency: accept at cycle T → FIFO write at end of T+1 → core_rsp_valid at T+2. Minimum 2 cycles.
- Throughput: 1 response per cycle sustained when core_rsp_ready=1 continuously.
- Ordering: strictly in issue order.
- Output holding: while core_rsp_valid & !core_rsp_ready, core_rsp_data/tag/tid stay stable.
- almost_full: registered, derived from the next-cycle reserved count.

Optional Feature:
- Macro: VX_BANK_RSPQ_PERF_EN.
- When defined, adds two outputs:
  - perf_rsp_stalls [31:0]: counts cycles with core_rsp_valid & !core_rsp_ready.
  - perf_issue_stalls [31:0]: counts cycles with rd_valid & !rd_ready.
- Both counters saturate at 32'hFFFFFFFF and clear on reset.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Single read, wsel=3, line_data word3=32'hDEADBEEF, tag=16'h00A5, tid=2, ready held 1 → core_rsp_valid exactly at T+2 with data DEADBEEF, tag 00A5, tid 2; then valid drops.
- Back-to-back: 8 reads on consecutive cycles, wsel 0..7, ready=1 → 8 responses on consecutive cycles starting T+2, in order, rd_ready never low.
- Backpressure: ready=0, issue continuously → exactly 4 accepted; rd_ready low thereafter; almost_full high once reserved=3; data stable. Raise ready → 4 pops, then issue resumes the cycle after the first pop registers.
- Wrap-around: 10 push/pop cycles with ready toggling 1010… → all 10 responses correct and ordered across pointer wrap.
- Reset with 3 queued entries plus 1 in S1 → next cycle core_rsp_valid=0, rd_ready=1; the stale S1 word never appears.
- VX_BANK_RSPQ_PERF_EN: 5 cycles of ready=0 with a valid response and 2 refused issues → perf_rsp_stalls=5, perf_issue_stalls=2.
